// File: rtl/instr_fetch.sv
// Instruction fetch unit: keeps the PC, reads a synchronous instruction memory and issues
// decoded fields to decode/execute under a valid/ready handshake.
module instr_fetch #(
   parameter int unsigned       ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] PC_RESET = '0,
   parameter logic [5:0]        HALT_OP  = 6'h3F
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_data,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [5:0]        Opcode,
   output logic [5:0]        FUNCT,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [15:0]       imm,
   output logic [25:0]       jaddr,
   output logic [ADDR_W-1:0] pc_out,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              halted
);

   localparam logic [5:0] JumpOp = 6'h02;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StWait,
      StIssue,
      StHalt
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_ir_q, pc_ir_d;
   logic [31:0]       ir_q, ir_d;
   logic              handshake;
   logic              redirect_active;

   assign handshake       = (state_q == StIssue) && instr_ready;
   assign redirect_active = redirect &&
                            ((state_q == StFetch) || (state_q == StWait) || (state_q == StIssue));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      pc_ir_d = pc_ir_q;

      case (state_q)
         StIdle: begin
            if (redirect) begin
               pc_d = redirect_addr;
            end else if (en) begin
               state_d = StFetch;
            end
         end
         StFetch: begin
            state_d = StWait;
         end
         StWait: begin
            ir_d    = mem_data;
            pc_ir_d = pc_q;
            state_d = StIssue;
         end
         StIssue: begin
            if (handshake) begin
               if (ir_q[31:26] == HALT_OP) begin
                  state_d = StHalt;
               end else begin
                  if (ir_q[31:26] == JumpOp) begin
                     pc_d = ir_q[ADDR_W-1:0];
                  end else begin
                     pc_d = pc_q + ADDR_W'(1);
                  end
                  state_d = en ? StFetch : StIdle;
               end
            end
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A redirect squashes the pending read or issue and restarts fetch at the target.
      if (redirect_active) begin
         pc_d    = redirect_addr;
         state_d = StFetch;
         ir_d    = ir_q;
         pc_ir_d = pc_ir_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         pc_q    <= PC_RESET;
         pc_ir_q <= PC_RESET;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pc_ir_q <= pc_ir_d;
         ir_q    <= ir_d;
      end
   end

   assign mem_addr    = pc_q;
   assign mem_rd      = (state_q == StFetch);
   assign instr_valid = (state_q == StIssue);
   assign halted      = (state_q == StHalt);

   assign Opcode = ir_q[31:26];
   assign FUNCT  = ir_q[5:0];
   assign rs     = ir_q[25:21];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign imm    = ir_q[15:0];
   assign jaddr  = ir_q[25:0];
   assign pc_out = pc_ir_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed fetch/jump/stall/redirect/halt/reset steps, then a
// randomized run checked against a transaction-level model of the issued instruction stream.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        instr_ready;
   logic        redirect;
   logic [7:0]  redirect_addr;

   logic [7:0]  a_mem_addr, b_mem_addr;
   logic        a_mem_rd, b_mem_rd;
   logic [31:0] a_mem_data = '0, b_mem_data = '0;
   logic        a_valid, b_valid;
   logic [5:0]  a_opcode, b_opcode, a_funct, b_funct;
   logic [4:0]  a_rs, a_rt, a_rd, b_rs, b_rt, b_rd;
   logic [15:0] a_imm, b_imm;
   logic [25:0] a_jaddr, b_jaddr;
   logic [7:0]  a_pc_out, b_pc_out;
   logic        a_halted, b_halted;

   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_fetch #(.ADDR_W(8), .PC_RESET(8'h00), .HALT_OP(6'h3F)) u_dut_a (
      .clk(clk), .reset(reset), .en(en),
      .mem_addr(a_mem_addr), .mem_rd(a_mem_rd), .mem_data(a_mem_data),
      .instr_valid(a_valid), .instr_ready(instr_ready),
      .Opcode(a_opcode), .FUNCT(a_funct), .rs(a_rs), .rt(a_rt), .rd(a_rd),
      .imm(a_imm), .jaddr(a_jaddr), .pc_out(a_pc_out),
      .redirect(redirect), .redirect_addr(redirect_addr), .halted(a_halted)
   );

   instr_fetch #(.ADDR_W(8), .PC_RESET(8'hFF), .HALT_OP(6'h3F)) u_dut_b (
      .clk(clk), .reset(reset), .en(en),
      .mem_addr(b_mem_addr), .mem_rd(b_mem_rd), .mem_data(b_mem_data),
      .instr_valid(b_valid), .instr_ready(instr_ready),
      .Opcode(b_opcode), .FUNCT(b_funct), .rs(b_rs), .rt(b_rt), .rd(b_rd),
      .imm(b_imm), .jaddr(b_jaddr), .pc_out(b_pc_out),
      .redirect(redirect), .redirect_addr(redirect_addr), .halted(b_halted)
   );

   // Synchronous instruction memories: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (a_mem_rd) a_mem_data <= mem_a[a_mem_addr];
      if (b_mem_rd) b_mem_data <= mem_b[b_mem_addr];
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout observed=running required=finished");
      $fatal(1, "simulation time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps negedges until the selected DUT shows instr_valid; n counts the cycles taken.
   task automatic wait_valid(input bit use_b, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(use_b ? b_valid : a_valid) && n < 20);
      if (!(use_b ? b_valid : a_valid)) begin
         checks++;
         failures++;
         $error("FAIL wait_valid observed=no_valid expected=valid_within_20");
      end
   endtask

   initial begin
      int          n;
      int          hs;
      logic [7:0]  exp_pc;
      logic [31:0] w;
      logic [5:0]  stall_op;

      for (int i = 0; i < 256; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      mem_a[8'h00] = 32'h0128_4020;
      mem_a[8'h01] = 32'h2008_0005;
      mem_a[8'h02] = 32'h3400_0000;
      mem_a[8'h03] = 32'h8C01_0004;
      mem_a[8'h04] = 32'h0800_0010;
      mem_a[8'h10] = 32'h0022_182A;
      mem_a[8'h11] = 32'h1000_0003;
      mem_a[8'h40] = 32'hAC22_0008;
      mem_b[8'h00] = 32'hFC00_0000;

      reset = 1'b1; en = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", a_valid, 1'b0);
      chk("rst_mem_rd", a_mem_rd, 1'b0);
      chk("rst_halted", a_halted, 1'b0);
      chk("rst_mem_addr", a_mem_addr, 8'h00);
      chk("rst_opcode", a_opcode, 6'h00);
      chk("rst_jaddr", a_jaddr, 26'h0);
      chk("rst_b_mem_addr", b_mem_addr, 8'hFF);

      // Sequential fetch: issues at cycles 3, 6, 9.
      reset = 1'b0; en = 1'b1; instr_ready = 1'b1;
      @(negedge clk);
      chk("c1_mem_rd", a_mem_rd, 1'b1);
      chk("c1_mem_addr", a_mem_addr, 8'h00);
      @(negedge clk);
      chk("c2_mem_rd", a_mem_rd, 1'b0);
      chk("c2_valid", a_valid, 1'b0);
      @(negedge clk);
      chk("c3_valid", a_valid, 1'b1);
      chk("i0_pc", a_pc_out, 8'h00);
      chk("i0_opcode", a_opcode, 6'h00);
      chk("i0_funct", a_funct, 6'h20);
      wait_valid(1'b0, n);
      chk("i1_gap", n, 3);
      chk("i1_pc", a_pc_out, 8'h01);
      chk("i1_opcode", a_opcode, 6'h08);
      chk("i1_imm", a_imm, 16'h0005);
      wait_valid(1'b0, n);
      chk("i2_gap", n, 3);
      chk("i2_pc", a_pc_out, 8'h02);
      chk("i2_opcode", a_opcode, 6'h0D);

      // Jump at address 4 to 0x10.
      wait_valid(1'b0, n);
      chk("i3_pc", a_pc_out, 8'h03);
      wait_valid(1'b0, n);
      chk("jmp_pc", a_pc_out, 8'h04);
      chk("jmp_opcode", a_opcode, 6'h02);
      @(negedge clk);
      chk("jmp_fetch_rd", a_mem_rd, 1'b1);
      chk("jmp_fetch_addr", a_mem_addr, 8'h10);
      wait_valid(1'b0, n);
      chk("jmp_target_pc", a_pc_out, 8'h10);
      chk("jmp_target_funct", a_funct, 6'h2A);

      // Stall for five cycles in ISSUE.
      instr_ready = 1'b0;
      stall_op = a_opcode;
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", a_valid, 1'b1);
         chk("stall_pc", a_pc_out, 8'h10);
         chk("stall_opcode", a_opcode, stall_op);
         chk("stall_funct", a_funct, 6'h2A);
         chk("stall_mem_rd", a_mem_rd, 1'b0);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      chk("release_rd", a_mem_rd, 1'b1);
      chk("release_addr", a_mem_addr, 8'h11);

      // Redirect in WAIT: the 0x11 read is dropped.
      @(negedge clk);
      redirect = 1'b1; redirect_addr = 8'h40;
      @(negedge clk);
      redirect = 1'b0;
      chk("redir_wait_rd", a_mem_rd, 1'b1);
      chk("redir_wait_addr", a_mem_addr, 8'h40);
      chk("redir_wait_valid", a_valid, 1'b0);
      wait_valid(1'b0, n);
      chk("redir_wait_gap", n, 2);
      chk("redir_wait_pc", a_pc_out, 8'h40);
      chk("redir_wait_opcode", a_opcode, 6'h2B);

      // Redirect coinciding with a handshake: redirect wins.
      redirect = 1'b1; redirect_addr = 8'h40;
      @(negedge clk);
      redirect = 1'b0;
      chk("redir_hs_valid", a_valid, 1'b0);
      chk("redir_hs_rd", a_mem_rd, 1'b1);
      chk("redir_hs_addr", a_mem_addr, 8'h40);
      wait_valid(1'b0, n);
      chk("redir_hs_pc", a_pc_out, 8'h40);

      // Reset while in ISSUE.
      reset = 1'b1; en = 1'b0;
      @(negedge clk);
      chk("rst_issue_valid", a_valid, 1'b0);
      chk("rst_issue_halted", a_halted, 1'b0);
      chk("rst_issue_addr", a_mem_addr, 8'h00);
      chk("rst_issue_rd", a_mem_rd, 1'b0);
      reset = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("idle_no_rd", a_mem_rd, 1'b0);
      end

      // Wrap from 0xFF to 0x00, then halt.
      en = 1'b1;
      wait_valid(1'b1, n);
      chk("wrap_gap", n, 3);
      chk("wrap_pc0", b_pc_out, 8'hFF);
      wait_valid(1'b1, n);
      chk("wrap_pc1", b_pc_out, 8'h00);
      chk("halt_opcode", b_opcode, 6'h3F);
      @(negedge clk);
      chk("halt_halted", b_halted, 1'b1);
      chk("halt_valid", b_valid, 1'b0);
      redirect_addr = 8'h20;
      repeat (4) begin
         redirect = ~redirect;
         @(negedge clk);
         chk("halt_rd", b_mem_rd, 1'b0);
         chk("halt_stays", b_halted, 1'b1);
         chk("halt_no_valid", b_valid, 1'b0);
      end
      redirect = 1'b0;

      // Reset while in HALT.
      reset = 1'b1; en = 1'b0;
      @(negedge clk);
      chk("rst_halt_halted", b_halted, 1'b0);
      chk("rst_halt_valid", b_valid, 1'b0);
      chk("rst_halt_addr", b_mem_addr, 8'hFF);
      chk("rst_halt_rd", b_mem_rd, 1'b0);

      // Randomized run: model tracks only the address of the next instruction to be issued.
      for (int i = 0; i < 256; i++) begin
         w = $urandom;
         if (w[31:26] == 6'h3F) w[31:26] = 6'h00;
         if ($urandom_range(7) == 0) w[31:26] = 6'h02;
         mem_a[i] = w;
      end
      @(negedge clk);
      reset = 1'b0; en = 1'b1;
      exp_pc = 8'h00;
      hs = 0;
      for (int c = 0; c < 3000; c++) begin
         instr_ready   = ($urandom_range(3) != 0);
         redirect      = ($urandom_range(19) == 0);
         redirect_addr = 8'($urandom);
         if (a_valid && instr_ready) begin
            w = mem_a[exp_pc];
            chk("rnd_pc", a_pc_out, exp_pc);
            chk("rnd_opcode", a_opcode, w[31:26]);
            chk("rnd_funct", a_funct, w[5:0]);
            chk("rnd_jaddr", a_jaddr, w[25:0]);
            hs++;
            exp_pc = (w[31:26] == 6'h02) ? w[7:0] : exp_pc + 8'h01;
         end
         if (redirect) exp_pc = redirect_addr;
         @(negedge clk);
      end
      redirect = 1'b0;
      chk("rnd_progress", (hs > 200), 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that drives the opcode/funct side of the control unit. It keeps the program counter and reads 32-bit words from a synchronous instruction memory. It splits each word into the fields the control unit and datapath consume: Opcode, FUNCT, register indices, immediate and jump target. Instructions are issued to the decode/execute stage under a valid/ready handshake, with support for jumps, datapath redirects (branches) and a halt instruction.

## Interface
- ADDR_W, 8, instruction memory word-address width; PC width.
- PC_RESET, 0, PC value loaded on reset.
- HALT_OP, 6'h3F, opcode that halts fetch.
- clk  in  1  single system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable, sampled in IDLE and on each issue handshake.
- mem_addr  out  ADDR_W  instruction memory word address, equals pc.
- mem_rd  out  1  read strobe to instruction memory.
- mem_data  in  32  read data, valid the cycle after mem_rd.
- instr_valid  out  1  issued fields valid.
- instr_ready  in  1  decode/execute accepts the current instruction.
- Opcode  out  6  ir[31:26], to the control unit.
- FUNCT  out  6  ir[5:0], to the control unit.
- rs, rt, rd  out  5 each  ir[25:21], ir[20:16], ir[15:11].
- imm  out  16  ir[15:0].
- jaddr  out  26  ir[25:0].
- pc_out  out  ADDR_W  address of the issued instruction.
- redirect  in  1  branch/redirect request from the datapath.
- redirect_addr  in  ADDR_W  redirect target.
- halted  out  1  high once HALT_OP has been issued.

## Operation
- States: IDLE, FETCH, WAIT, ISSUE, HALT.
- IDLE: mem_rd=0, instr_valid=0; en=1 -> FETCH.
- FETCH: mem_rd=1, mem_addr=pc -> WAIT.
- WAIT: ir <= mem_data -> ISSUE.
- ISSUE: instr_valid=1 and the fields decode from ir; all outputs hold stable while instr_ready=0.
- The handshake completes on the clk edge where instr_valid & instr_ready are both high.
- Next pc on handshake:
  - Opcode==6'h2 (jump): pc <= jaddr[ADDR_W-1:0].
  - Opcode==HALT_OP: pc unchanged, -> HALT.
  - Otherwise: pc <= pc+1, wrapping modulo 2^ADDR_W.
- After a non-halt handshake: -> FETCH if en=1, else -> IDLE.
- HALT: halted=1, mem_rd=0, instr_valid=0; only reset leaves HALT. en and redirect are ignored.
- redirect=1 in FETCH, WAIT or ISSUE:
  - pc <= redirect_addr, -> FETCH.
  - Any in-flight read data is discarded and any pending ISSUE is dropped without a handshake.
  - instr_valid is 0 from the next cycle.
- redirect in IDLE: pc <= redirect_addr, state unchanged.
- Priority: reset > redirect > handshake > en.
- pc_out holds the pc latched with the instruction in ir, not the next pc.

## Timing
- Reset values: pc=PC_RESET, state IDLE, ir=0, mem_addr=PC_RESET, mem_rd=0, instr_valid=0, halted=0. All field outputs are 0.
- Reset mid-operation (any state, including HALT) returns everything to these reset values on the next edge. A pending read result is ignored.
- Latency, en high in IDLE at cycle 0:
  - cycle 1: FETCH (mem_rd=1).
  - cycle 2: WAIT.
  - cycle 3: ISSUE (instr_valid=1).
- Throughput: with instr_ready tied high, one instruction per 3 cycles.
- Each cycle instr_ready is low in ISSUE adds one cycle. Fields must not change during the stall.
- Redirect asserted in cycle N: FETCH of redirect_addr happens in cycle N+1, and instr_valid for it in cycle N+3.
- Redirect and handshake in the same cycle: the redirect wins and the next pc is redirect_addr. The handshake still counts as accepted by the consumer; the consumer is responsible for squashing.
- mem_rd is a single-cycle pulse per fetch and is never asserted in WAIT, ISSUE, IDLE or HALT.

## Test plan
- Sequential fetch: memory[0..2] = add (Opcode 0, FUNCT 6'h20), 32'h2008_0005 (addi), 32'h3400_0000. Reset, then en=1, instr_ready=1 -> three issues at cycles 3, 6 and 9 with pc_out 0, 1, 2. Fields: Opcode 0 / FUNCT 6'h20, then Opcode 6'h8 / imm 16'h0005, then Opcode 6'hd.
- Jump: memory[4]=32'h0800_0010 -> after its handshake, the next mem_addr is 8'h10 and the next pc_out is 8'h10.
- Stall: hold instr_ready=0 for 5 cycles in ISSUE -> instr_valid stays 1, Opcode/FUNCT/pc_out stay constant, and no mem_rd pulse occurs. Release -> the next FETCH happens on the following cycle.
- Redirect in WAIT: redirect=1 with redirect_addr=8'h40 -> the pending instruction is never issued and FETCH at 8'h40 follows on the next cycle. Same test with redirect coinciding with a handshake -> pc becomes 8'h40.
- Wrap and halt: PC_RESET=8'hFF, memory[8'hFF]=nop, memory[0]=32'hFC00_0000 -> the first pc_out is 8'hFF and the second is 8'h00. After the second handshake, halted=1 and mem_rd stays 0 with redirect pulsing.
- Reset mid-op: assert reset in ISSUE and in HALT -> the next cycle shows instr_valid=0, halted=0, mem_addr=PC_RESET.
